// File: rtl/core_pkg.sv
// Shared core types: data-memory op codes, writeback select codes and the
// EX/MA stage-register bundle with its bubble value.
package core_pkg;

    localparam int IM_ADDR_NBIT = 16;
    localparam int DM_OP_NBIT = 4;
    localparam int MUX_RFD_NBIT = 2;

    typedef enum logic [DM_OP_NBIT-1:0] {
        DM_NONE = 4'd0,
        DM_LW   = 4'd1,
        DM_LB   = 4'd2,
        DM_LBU  = 4'd3,
        DM_LH   = 4'd4,
        DM_LHU  = 4'd5,
        DM_SW   = 4'd6,
        DM_SB   = 4'd7,
        DM_SH   = 4'd8
    } dm_op_e;

    typedef enum logic [MUX_RFD_NBIT-1:0] {
        RFD_ALU = 2'd0,
        RFD_MEM = 2'd1,
        RFD_PC4 = 2'd2
    } mux_rfd_e;

    typedef struct packed {
        logic [IM_ADDR_NBIT-1:0] pc_4;
        logic [31:0]             alu;
        logic [31:0]             st_data;
        dm_op_e                  dm_op;
        logic                    rf_we;
        logic [4:0]              waddr;
        mux_rfd_e                mux;
        logic                    halt;
    } ex_ma_t;

    localparam ex_ma_t EX_MA_BUBBLE = '{
        pc_4:    '0,
        alu:     '0,
        st_data: '0,
        dm_op:   DM_NONE,
        rf_we:   1'b0,
        waddr:   '0,
        mux:     RFD_ALU,
        halt:    1'b0
    };

    function automatic logic is_load(dm_op_e op);
        return op inside {DM_LW, DM_LB, DM_LBU, DM_LH, DM_LHU};
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised data memory: byte-enabled synchronous write,
// combinational read, single shared address.
module dm_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/pst_ma.sv
// Memory-access pipeline stage: EX/MA register, data memory, writeback mux.
// Byte/halfword accesses are compiled in only when DM_SUBWORD_EN is defined.
module pst_ma
    import core_pkg::*;
#(
    parameter int DM_ADDR_NBIT = 10,
    parameter int MIS_CNT_NBIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [IM_ADDR_NBIT-1:0] pc_4,
    input  logic [31:0]             alu_data_res,
    input  logic [31:0]             rf_data_b,
    input  logic [DM_OP_NBIT-1:0]   ctl_dm_op,
    input  logic                    ctl_rf_we,
    input  logic [4:0]              rf_waddr_in,
    input  logic [MUX_RFD_NBIT-1:0] mux_rf_data,
    input  logic                    halt_in,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic                    halt,
    output logic                    misaligned,
    output logic [MIS_CNT_NBIT-1:0] mis_cnt
);

    ex_ma_t stage_d, stage_q;
    logic [MIS_CNT_NBIT-1:0] mis_cnt_d, mis_cnt_q;

    logic [31:0]             addr;
    logic [1:0]              off;
    logic [DM_ADDR_NBIT-1:0] idx;
    logic                    unused_addr;
    logic [31:0]             rdata, st_wdata, ld_data;
    logic [3:0]              be;
    logic                    mis, dm_we;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            if (flush) begin
                stage_d = EX_MA_BUBBLE;
            end else begin
                stage_d.pc_4    = pc_4;
                stage_d.alu     = alu_data_res;
                stage_d.st_data = rf_data_b;
                stage_d.dm_op   = dm_op_e'(ctl_dm_op);
                stage_d.rf_we   = ctl_rf_we;
                stage_d.waddr   = rf_waddr_in;
                stage_d.mux     = mux_rfd_e'(mux_rf_data);
                stage_d.halt    = halt_in;
            end
        end
    end

    // Upper address bits are dropped, so accesses wrap around the memory.
    assign addr        = stage_q.alu;
    assign off         = addr[1:0];
    assign idx         = addr[DM_ADDR_NBIT+1:2];
    assign unused_addr = ^addr[31:DM_ADDR_NBIT+2];

`ifdef DM_SUBWORD_EN
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{off, 3'b000} +: 8];
    assign half_v = off[1] ? rdata[31:16] : rdata[15:0];
`endif

    always_comb begin
        mis      = 1'b0;
        be       = 4'b0000;
        st_wdata = stage_q.st_data;
        ld_data  = '0;
        case (stage_q.dm_op)
            DM_LW: begin
                mis     = (off != 2'b00);
                ld_data = rdata;
            end
            DM_SW: begin
                mis = (off != 2'b00);
                be  = 4'b1111;
            end
`ifdef DM_SUBWORD_EN
            DM_LB:  ld_data = {{24{byte_v[7]}}, byte_v};
            DM_LBU: ld_data = {24'd0, byte_v};
            DM_LH: begin
                mis     = off[0];
                ld_data = {{16{half_v[15]}}, half_v};
            end
            DM_LHU: begin
                mis     = off[0];
                ld_data = {16'd0, half_v};
            end
            DM_SB: begin
                be       = 4'b0001 << off;
                st_wdata = {4{stage_q.st_data[7:0]}};
            end
            DM_SH: begin
                mis      = off[0];
                be       = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{stage_q.st_data[15:0]}};
            end
`endif
            default: ;
        endcase
    end

    // The store commits on the edge that retires it from this stage.
    assign dm_we = en & ~mis & (be != 4'b0000);

    dm_ram #(
        .AW(DM_ADDR_NBIT)
    ) u_dm_ram (
        .clk  (clk),
        .we   (dm_we),
        .be   (be),
        .addr (idx),
        .wdata(st_wdata),
        .rdata(rdata)
    );

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (en && mis && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + MIS_CNT_NBIT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= EX_MA_BUBBLE;
            mis_cnt_q <= '0;
        end else begin
            stage_q   <= stage_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    always_comb begin
        case (stage_q.mux)
            RFD_ALU: rf_wdata = stage_q.alu;
            RFD_MEM: rf_wdata = ld_data;
            RFD_PC4: rf_wdata = {{(32-IM_ADDR_NBIT){1'b0}}, stage_q.pc_4};
            default: rf_wdata = '0;
        endcase
    end

    assign rf_we = stage_q.rf_we & (stage_q.waddr != 5'd0)
                 & ~(mis & is_load(stage_q.dm_op));
    assign rf_waddr   = stage_q.waddr;
    assign halt       = stage_q.halt;
    assign misaligned = mis;
    assign mis_cnt    = mis_cnt_q;

endmodule
